imem_loader: RTL
================

# imem_loader

Serial program loader that writes instruction memory, the write side of the instruction-fetch path. It accepts a framed byte stream on a valid/ready interface, packs the bytes into 32-bit little-endian words and issues single-cycle writes to the instruction memory port. While loading it holds the CPU through `cpu_stall`. On success it pulses `pc_clear` so the fetch unit restarts at address 0.

## Interface
- `ADDR_W`, default 14: word-address width of instruction memory. Legal range is 1..16.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: arm or re-arm the loader. Single-cycle pulse, sampled every cycle.
- `rx_data`  in  8: incoming byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader accepts a byte. A byte is consumed on a rising edge where `rx_valid && rx_ready`.
- `imem_we`  out  1: instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W: word address.
- `imem_wdata`  out  32: word to write.
- `cpu_stall`  out  1: hold the fetch unit's PC.
- `pc_clear`  out  1: one-cycle pulse that resets the fetch PC to 0.
- `done`  out  1: load succeeded. Level signal, held until the next `start`.
- `error`  out  1: load failed. Level signal, held until the next `start`.

## Operation
- Frame format:
  - Sync byte 0xA5.
  - Word count N, 16-bit little-endian (low byte first).
  - N×4 payload bytes, each word little-endian.
  - Checksum byte, only when the configuration macro is defined (see Configuration).
- States: IDLE, SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
- IDLE: `rx_ready`=0, `cpu_stall`=0. `start` moves to SYNC and clears the word counter, byte counter, checksum, `done` and `error`.
- SYNC: `rx_ready`=1. Accepted bytes other than 0xA5 are discarded. Accepting 0xA5 moves to LEN_LO.
- LEN_LO → LEN_HI: capture N.
- At LEN_HI accept:
  - N > 2**ADDR_W → ERR.
  - N = 0 → CHECK if the macro is defined, otherwise DONE.
  - Otherwise → DATA.
- DATA: a 2-bit byte counter places byte i at bits [8i+7:8i].
  - On the 4th byte: `imem_wdata` ← packed word, `imem_addr` ← word counter, `imem_we`=1 for the following cycle. The word counter then increments.
  - After word N-1, go to CHECK or DONE.
- CHECK: accept one byte. If it equals the XOR of all payload bytes → DONE, otherwise → ERR.
- DONE: `done`=1, `cpu_stall`=0. `pc_clear` is high for exactly the first cycle in DONE. Stays in DONE until `start`.
- ERR: `error`=1, `cpu_stall`=1 (the CPU never runs a corrupt image), `rx_ready`=0. Stays in ERR until `start`.
- `cpu_stall`=1 in SYNC, LEN_LO, LEN_HI, DATA, CHECK and ERR.
- `start` in any non-IDLE state aborts to SYNC with counters cleared. A partially assembled word is dropped; completed writes remain in memory.
- `rx_ready` is a Moore output: 1 in SYNC, LEN_LO, LEN_HI, DATA and CHECK, 0 elsewhere.

## Timing
- Reset values: state IDLE; `rx_ready`, `imem_we`, `cpu_stall`, `pc_clear`, `done`, `error` all 0; `imem_addr`=0; `imem_wdata`=0.
- Write latency: the 4th byte is accepted at edge k; `imem_we`, `imem_addr` and `imem_wdata` are valid from k to k+1, and the memory commits the word at edge k+1.
- A byte may be accepted during the `imem_we` cycle. `imem_wdata` is a separate register from the packing register.
- Without the checksum macro, DONE is entered at edge k+1, never before the final write commits. `pc_clear` is high from k+1 to k+2.
- `rx_valid` gaps of any length are legal; state is held.
- `start` coinciding with a byte handshake: `start` wins and the byte is discarded.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`:
  - Defined: CHECK state exists and the frame carries a trailing XOR checksum byte. A mismatch → ERR.
  - Undefined: no checksum byte is expected, the CHECK state and XOR register are compiled out, and `error` is raised only for length overflow.

## Structure
- Package `imem_loader_pkg`:
  - State enum.
  - `SYNC_BYTE` = 8'hA5.
  - `LEN_W` = 16.
- Sub-module `word_packer`: a 4-byte little-endian shift/packing register with byte counter and `word_valid` pulse. Instantiated once.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DATA → all outputs 0 immediately, state IDLE, no `imem_we`.
- **Basic load:** `start`, then A5 02 00 78 56 34 12 EF BE AD DE, plus 2A when the macro is defined.
  - addr 0 ← 0x12345678, addr 1 ← 0xDEADBEEF.
  - `done`=1, single `pc_clear` pulse, `cpu_stall` falls.
- **Noise before sync:** 00 FF 13 precede the frame → ignored; same writes as the basic load.
- **Bad checksum (macro defined):** last byte 2B → `error`=1, `cpu_stall`=1, `done`=0; both words still written.
- **Abort and idle gaps:** `start` after 2 payload bytes → no write; resend the full frame → writes start at addr 0. Random `rx_valid` gaps → identical results.
- **Length limits:**
  - N=0 (plus checksum 00 when the macro is defined) → DONE with no writes.
  - ADDR_W=2, N=5 → ERR right after LEN_HI.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Optional checksum build: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         LEN_W     = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_e;

endpackage

// File: rtl/word_packer.sv
// Packs four bytes into a 32-bit little-endian word.
// word_valid_o pulses with the 4th byte; word_o is valid then.
module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  cnt_q;
   logic [23:0] pack_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         pack_q <= 24'd0;
      end else if (clear_i) begin
         cnt_q  <= 2'd0;
         pack_q <= 24'd0;
      end else if (byte_valid_i) begin
         cnt_q <= cnt_q + 2'd1;
         case (cnt_q)
            2'd0:    pack_q[7:0]   <= byte_i;
            2'd1:    pack_q[15:8]  <= byte_i;
            2'd2:    pack_q[23:16] <= byte_i;
            default: ;
         endcase
      end
   end

   // Top byte bypasses the register so the word is ready on the 4th byte.
   assign word_o       = {byte_i, pack_q};
   assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN for the trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_stall,
   output logic              pc_clear,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W:0] MAX_N =
      {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e S_TAIL = S_CHECK;
`else
   localparam state_e S_TAIL = S_DONE;
`endif

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  wcnt_q;
   logic              fin_q;
   logic              rx_ready_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              stall_q;
   logic              pcc_q;
   logic              done_q;
   logic              err_q;

   logic              acc;
   logic              pk_valid;
   logic              word_valid;
   logic [31:0]       word;
   logic [LEN_W-1:0]  len_n;
   logic              last_word;

   assign acc       = rx_valid && rx_ready_q && !start;
   assign pk_valid  = acc && (state_q == S_DATA) && !fin_q;
   assign len_n     = {rx_data, len_q[7:0]};
   assign last_word = (wcnt_q == len_q - 16'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        csum_q <= 8'd0;
      else if (start)    csum_q <= 8'd0;
      else if (pk_valid) csum_q <= csum_q ^ rx_data;
   end
`endif

   word_packer u_pack (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (start),
      .byte_i       (rx_data),
      .byte_valid_i (pk_valid),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_SYNC;
      end else begin
         unique case (state_q)
            S_SYNC:
               if (acc && rx_data == SYNC_BYTE)
                  state_d = S_LEN_LO;
            S_LEN_LO:
               if (acc) state_d = S_LEN_HI;
            S_LEN_HI:
               if (acc) begin
                  if ({1'b0, len_n} > MAX_N)
                     state_d = S_ERR;
                  else if (len_n == '0)
                     state_d = S_TAIL;
                  else
                     state_d = S_DATA;
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_DATA:
               if (word_valid && last_word)
                  state_d = S_CHECK;
            S_CHECK:
               if (acc)
                  state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
`else
            // Wait one cycle so the final write commits before DONE.
            S_DATA:
               if (fin_q) state_d = S_DONE;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         wcnt_q     <= '0;
         fin_q      <= 1'b0;
         rx_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         stall_q    <= 1'b0;
         pcc_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_ready_q <= state_d inside {S_SYNC, S_LEN_LO,
                       S_LEN_HI, S_DATA, S_CHECK};
         stall_q    <= state_d inside {S_SYNC, S_LEN_LO,
                       S_LEN_HI, S_DATA, S_CHECK, S_ERR};
         done_q     <= (state_d == S_DONE);
         err_q      <= (state_d == S_ERR);
         pcc_q      <= (state_d == S_DONE) &&
                       (state_q != S_DONE);
         we_q       <= word_valid;
         if (state_q == S_LEN_LO && acc)
            len_q[7:0] <= rx_data;
         if (state_q == S_LEN_HI && acc)
            len_q[15:8] <= rx_data;
         if (word_valid) begin
            wdata_q <= word;
            addr_q  <= wcnt_q[ADDR_W-1:0];
            wcnt_q  <= wcnt_q + 16'd1;
         end
         if (start) begin
            wcnt_q <= '0;
            fin_q  <= 1'b0;
         end else if (word_valid && last_word) begin
            fin_q  <= 1'b1;
         end
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_stall  = stall_q;
   assign pc_clear   = pcc_q;
   assign done       = done_q;
   assign error      = err_q;

endmodule
